// File: rtl/issue_scheduler.sv
// Multi-issue scheduler: matches ready RS entries to ready FUs of the same class,
// oldest-first by ROB age, with registered issue outputs and an in-flight mask.
module issue_scheduler #(
    parameter int NUM_RS = 8,
    parameter int NUM_FU = 4,
    parameter int ROB_W  = 3,
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter logic [2*NUM_FU-1:0] FU_CLASS = 8'h90
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [ROB_W-1:0]         rob_head,
    input  logic [NUM_RS-1:0]        rs_valid,
    input  logic [2*NUM_RS-1:0]      rs_class,
    input  logic [OP_W*NUM_RS-1:0]   rs_op,
    input  logic [2*NUM_RS-1:0]      rs_btype,
    input  logic [ROB_W*NUM_RS-1:0]  rs_rob,
    input  logic [DATA_W*NUM_RS-1:0] rs_src1,
    input  logic [DATA_W*NUM_RS-1:0] rs_src2,
    input  logic [NUM_FU-1:0]        fu_ready,
    output logic [NUM_FU-1:0]        fu_valid,
    output logic [OP_W*NUM_FU-1:0]   fu_op,
    output logic [2*NUM_FU-1:0]      fu_btype,
    output logic [ROB_W*NUM_FU-1:0]  fu_rob,
    output logic [DATA_W*NUM_FU-1:0] fu_src1,
    output logic [DATA_W*NUM_FU-1:0] fu_src2,
    output logic [NUM_RS-1:0]        rs_consumed
);

    logic [NUM_RS-1:0]        inflight_mask;

    logic [NUM_FU-1:0]        grant_p0;
    logic [NUM_RS-1:0]        taken_p0;
    logic [OP_W*NUM_FU-1:0]   op_p0;
    logic [2*NUM_FU-1:0]      btype_p0;
    logic [ROB_W*NUM_FU-1:0]  rob_p0;
    logic [DATA_W*NUM_FU-1:0] src1_p0;
    logic [DATA_W*NUM_FU-1:0] src2_p0;

    logic                     best_found;
    logic [ROB_W-1:0]         best_age;
    logic [ROB_W-1:0]         age;
    logic [NUM_RS-1:0]        best_onehot;
    logic [OP_W-1:0]          best_op;
    logic [1:0]               best_btype;
    logic [ROB_W-1:0]         best_rob;
    logic [DATA_W-1:0]        best_src1;
    logic [DATA_W-1:0]        best_src2;

    // Stage p0: combinational selection; lower-index FUs claim entries first,
    // strict less-than keeps the lowest entry index on an age tie.
    always_comb begin
        grant_p0    = '0;
        taken_p0    = '0;
        op_p0       = '0;
        btype_p0    = '0;
        rob_p0      = '0;
        src1_p0     = '0;
        src2_p0     = '0;
        best_found  = 1'b0;
        best_age    = '0;
        age         = '0;
        best_onehot = '0;
        best_op     = '0;
        best_btype  = '0;
        best_rob    = '0;
        best_src1   = '0;
        best_src2   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            best_found  = 1'b0;
            best_age    = '0;
            best_onehot = '0;
            best_op     = '0;
            best_btype  = '0;
            best_rob    = '0;
            best_src1   = '0;
            best_src2   = '0;
            if (fu_ready[i]) begin
                for (int e = 0; e < NUM_RS; e++) begin
                    // Unsigned modular distance from the head makes tag wrap transparent.
                    age = rs_rob[e*ROB_W +: ROB_W] - rob_head;
                    if (rs_valid[e] && !inflight_mask[e] && !taken_p0[e] &&
                        (rs_class[2*e +: 2] == FU_CLASS[2*i +: 2]) &&
                        (!best_found || (age < best_age))) begin
                        best_found  = 1'b1;
                        best_age    = age;
                        best_onehot = '0;
                        best_onehot[e] = 1'b1;
                        best_op     = rs_op[e*OP_W +: OP_W];
                        best_btype  = rs_btype[2*e +: 2];
                        best_rob    = rs_rob[e*ROB_W +: ROB_W];
                        best_src1   = rs_src1[e*DATA_W +: DATA_W];
                        best_src2   = rs_src2[e*DATA_W +: DATA_W];
                    end
                end
            end
            grant_p0[i]                  = best_found;
            taken_p0                     = taken_p0 | best_onehot;
            op_p0[i*OP_W +: OP_W]        = best_op;
            btype_p0[2*i +: 2]           = best_btype;
            rob_p0[i*ROB_W +: ROB_W]     = best_rob;
            src1_p0[i*DATA_W +: DATA_W]  = best_src1;
            src2_p0[i*DATA_W +: DATA_W]  = best_src2;
        end
    end

    // Stage p1: registered issue; data outputs only load on a grant and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            fu_valid      <= '0;
            rs_consumed   <= '0;
            inflight_mask <= '0;
            fu_op         <= '0;
            fu_btype      <= '0;
            fu_rob        <= '0;
            fu_src1       <= '0;
            fu_src2       <= '0;
        end else if (flush) begin
            fu_valid      <= '0;
            rs_consumed   <= '0;
            inflight_mask <= '0;
        end else begin
            fu_valid      <= grant_p0;
            rs_consumed   <= taken_p0;
            inflight_mask <= taken_p0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (grant_p0[i]) begin
                    fu_op[i*OP_W +: OP_W]       <= op_p0[i*OP_W +: OP_W];
                    fu_btype[2*i +: 2]          <= btype_p0[2*i +: 2];
                    fu_rob[i*ROB_W +: ROB_W]    <= rob_p0[i*ROB_W +: ROB_W];
                    fu_src1[i*DATA_W +: DATA_W] <= src1_p0[i*DATA_W +: DATA_W];
                    fu_src2[i*DATA_W +: DATA_W] <= src2_p0[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic against an
// oldest-first reference model built from a sorted candidate list.
module tb_issue_scheduler;

    localparam int NUM_RS = 8;
    localparam int NUM_FU = 4;
    localparam int ROB_W  = 3;
    localparam int DATA_W = 32;
    localparam int OP_W   = 3;
    localparam logic [2*NUM_FU-1:0] FU_CLASS_TB = 8'h90;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [ROB_W-1:0]         rob_head;
    logic [NUM_RS-1:0]        rs_valid;
    logic [2*NUM_RS-1:0]      rs_class;
    logic [OP_W*NUM_RS-1:0]   rs_op;
    logic [2*NUM_RS-1:0]      rs_btype;
    logic [ROB_W*NUM_RS-1:0]  rs_rob;
    logic [DATA_W*NUM_RS-1:0] rs_src1;
    logic [DATA_W*NUM_RS-1:0] rs_src2;
    logic [NUM_FU-1:0]        fu_ready;
    logic [NUM_FU-1:0]        fu_valid;
    logic [OP_W*NUM_FU-1:0]   fu_op;
    logic [2*NUM_FU-1:0]      fu_btype;
    logic [ROB_W*NUM_FU-1:0]  fu_rob;
    logic [DATA_W*NUM_FU-1:0] fu_src1;
    logic [DATA_W*NUM_FU-1:0] fu_src2;
    logic [NUM_RS-1:0]        rs_consumed;

    issue_scheduler dut (
        .clk(clk), .reset(reset), .flush(flush), .rob_head(rob_head),
        .rs_valid(rs_valid), .rs_class(rs_class), .rs_op(rs_op),
        .rs_btype(rs_btype), .rs_rob(rs_rob), .rs_src1(rs_src1),
        .rs_src2(rs_src2), .fu_ready(fu_ready), .fu_valid(fu_valid),
        .fu_op(fu_op), .fu_btype(fu_btype), .fu_rob(fu_rob),
        .fu_src1(fu_src1), .fu_src2(fu_src2), .rs_consumed(rs_consumed)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [NUM_RS-1:0] m_mask;
    logic [NUM_FU-1:0] e_valid;
    logic [NUM_RS-1:0] e_cons;
    logic [OP_W-1:0]   e_op   [NUM_FU];
    logic [1:0]        e_bt   [NUM_FU];
    logic [ROB_W-1:0]  e_rob  [NUM_FU];
    logic [DATA_W-1:0] e_s1   [NUM_FU];
    logic [DATA_W-1:0] e_s2   [NUM_FU];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int age_of(input int e);
        int r;
        r = int'(rs_rob[e*ROB_W +: ROB_W]) - int'(rob_head);
        return ((r % 8) + 8) % 8;
    endfunction

    task automatic set_entry(input int e, input int cls, input int op, input int bt,
                             input int rob, input logic [31:0] s1, input logic [31:0] s2);
        rs_valid[e]                = 1'b1;
        rs_class[2*e +: 2]         = cls[1:0];
        rs_op[e*OP_W +: OP_W]      = op[OP_W-1:0];
        rs_btype[2*e +: 2]         = bt[1:0];
        rs_rob[e*ROB_W +: ROB_W]   = rob[ROB_W-1:0];
        rs_src1[e*DATA_W +: DATA_W] = s1;
        rs_src2[e*DATA_W +: DATA_W] = s2;
    endtask

    task automatic randomize_inputs();
        rob_head = ROB_W'($urandom_range(7));
        rs_valid = NUM_RS'($urandom);
        rs_class = 16'($urandom);
        rs_op    = 24'($urandom);
        rs_btype = 16'($urandom);
        rs_rob   = 24'($urandom);
        fu_ready = NUM_FU'($urandom);
        for (int e = 0; e < NUM_RS; e++) begin
            rs_src1[e*DATA_W +: DATA_W] = $urandom;
            rs_src2[e*DATA_W +: DATA_W] = $urandom;
        end
    endtask

    // Predict next-cycle outputs from current inputs, clock once, compare everything.
    task automatic cycle();
        int q[$];
        logic [NUM_RS-1:0] g;
        logic [NUM_FU-1:0] gv;
        bit found;
        int e;
        if (reset) begin
            m_mask = '0; e_valid = '0; e_cons = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                e_op[i] = '0; e_bt[i] = '0; e_rob[i] = '0; e_s1[i] = '0; e_s2[i] = '0;
            end
        end else if (flush) begin
            m_mask = '0; e_valid = '0; e_cons = '0;
        end else begin
            for (int a = 0; a < 8; a++)
                for (int k = 0; k < NUM_RS; k++)
                    if (rs_valid[k] && !m_mask[k] && age_of(k) == a) q.push_back(k);
            g = '0; gv = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                found = 1'b0;
                if (fu_ready[i]) begin
                    for (int k = 0; k < q.size(); k++) begin
                        e = q[k];
                        if (!found && !g[e] && rs_class[2*e +: 2] == FU_CLASS_TB[2*i +: 2]) begin
                            found = 1'b1; g[e] = 1'b1; gv[i] = 1'b1;
                            e_op[i]  = rs_op[e*OP_W +: OP_W];
                            e_bt[i]  = rs_btype[2*e +: 2];
                            e_rob[i] = rs_rob[e*ROB_W +: ROB_W];
                            e_s1[i]  = rs_src1[e*DATA_W +: DATA_W];
                            e_s2[i]  = rs_src2[e*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            e_valid = gv; e_cons = g; m_mask = g;
        end
        @(posedge clk);
        #1;
        chk("fu_valid", 128'(fu_valid), 128'(e_valid));
        chk("rs_consumed", 128'(rs_consumed), 128'(e_cons));
        for (int i = 0; i < NUM_FU; i++) begin
            chk($sformatf("fu_op[%0d]", i),    128'(fu_op[i*OP_W +: OP_W]),       128'(e_op[i]));
            chk($sformatf("fu_btype[%0d]", i), 128'(fu_btype[2*i +: 2]),          128'(e_bt[i]));
            chk($sformatf("fu_rob[%0d]", i),   128'(fu_rob[i*ROB_W +: ROB_W]),    128'(e_rob[i]));
            chk($sformatf("fu_src1[%0d]", i),  128'(fu_src1[i*DATA_W +: DATA_W]), 128'(e_s1[i]));
            chk($sformatf("fu_src2[%0d]", i),  128'(fu_src2[i*DATA_W +: DATA_W]), 128'(e_s2[i]));
        end
    endtask

    initial begin
        m_mask = '0; e_valid = '0; e_cons = '0;
        // Reset held two cycles under random inputs
        reset = 1'b1; flush = 1'b0;
        randomize_inputs();
        cycle();
        randomize_inputs();
        cycle();
        chk("reset_all_data", {fu_op, fu_btype, fu_rob, fu_src1[31:0], fu_src2[31:0]}, '0);
        reset = 1'b0; rs_valid = '0;
        cycle();
        chk("post_reset_idle", 128'(fu_valid), 128'(0));

        // Two ALU entries, oldest first
        rs_valid = '0; rob_head = 3'd0; fu_ready = 4'b1111;
        set_entry(0, 0, 1, 0, 5, 32'h0000_1000, 32'h0000_2000);
        set_entry(3, 0, 2, 0, 2, 32'h0000_3000, 32'h0000_4000);
        cycle();
        chk("t2_valid", 128'(fu_valid), 128'(4'b0011));
        chk("t2_fu0_rob", 128'(fu_rob[2:0]), 128'(3'd2));
        chk("t2_fu1_rob", 128'(fu_rob[5:3]), 128'(3'd5));
        chk("t2_consumed", 128'(rs_consumed), 128'(8'b0000_1001));
        rs_valid = '0;
        cycle();

        // ROB tag wrap around the head
        rob_head = 3'd6; fu_ready = 4'b0001;
        set_entry(1, 0, 3, 0, 1, 32'hAAAA_0001, 32'hBBBB_0001);
        set_entry(2, 0, 4, 0, 7, 32'hAAAA_0002, 32'hBBBB_0002);
        cycle();
        chk("t3_fu0_rob7", 128'(fu_rob[2:0]), 128'(3'd7));
        chk("t3_consumed", 128'(rs_consumed), 128'(8'b0000_0100));
        rs_valid[2] = 1'b0;
        cycle();
        chk("t3_fu0_rob1", 128'(fu_rob[2:0]), 128'(3'd1));
        chk("t3_consumed2", 128'(rs_consumed), 128'(8'b0000_0010));
        rs_valid = '0;
        cycle();

        // MULDIV entry left valid three cycles: issue, masked, reissue
        rob_head = 3'd0; fu_ready = 4'b1111;
        set_entry(4, 1, 5, 0, 4, 32'h1234_5678, 32'h8765_4321);
        cycle();
        chk("t4_issue", 128'(fu_valid), 128'(4'b0100));
        cycle();
        chk("t4_masked", 128'(fu_valid), 128'(4'b0000));
        cycle();
        chk("t4_reissue", 128'(fu_valid), 128'(4'b0100));
        rs_valid = '0;
        cycle();

        // Branch entry waits for FU3 readiness
        fu_ready = 4'b0111;
        set_entry(5, 2, 6, 3, 3, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        cycle();
        chk("t5_no_issue", 128'(fu_valid), 128'(4'b0000));
        fu_ready = 4'b1111;
        cycle();
        chk("t5_fu3", 128'(fu_valid), 128'(4'b1000));
        chk("t5_btype", 128'(fu_btype[7:6]), 128'(2'd3));
        chk("t5_src1", 128'(fu_src1[127:96]), 128'(32'hDEAD_BEEF));
        rs_valid = '0;
        cycle();

        // Flush discards pending grants; issue resumes afterwards
        set_entry(0, 0, 1, 0, 3, 32'h0000_0011, 32'h0000_0022);
        set_entry(2, 1, 2, 0, 4, 32'h0000_0033, 32'h0000_0044);
        flush = 1'b1;
        cycle();
        chk("t6_flush_valid", 128'(fu_valid), 128'(0));
        chk("t6_flush_cons", 128'(rs_consumed), 128'(0));
        flush = 1'b0;
        cycle();
        chk("t6_resume", 128'(fu_valid), 128'(4'b0101));
        chk("t6_resume_cons", 128'(rs_consumed), 128'(8'b0000_0101));
        rs_valid = '0;
        cycle();

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            flush = ($urandom_range(15) == 0);
            reset = ($urandom_range(63) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
